// File: rtl/drp_arbiter.sv
// Round-robin arbiter sharing one DRP device port among PORTS requesters.
// Requests are latched per port, issued one at a time, and a watchdog forces completion.
module drp_arbiter #(
  parameter int PORTS      = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS*ADDR_WIDTH-1:0]   s_drp_addr,
  input  logic [PORTS*16-1:0]           s_drp_di,
  output logic [PORTS*16-1:0]           s_drp_do,
  input  logic [PORTS-1:0]              s_drp_en,
  input  logic [PORTS-1:0]              s_drp_we,
  output logic [PORTS-1:0]              s_drp_rdy,
  output logic [PORTS-1:0]              s_drp_drop,
  output logic [ADDR_WIDTH-1:0]         m_drp_addr,
  output logic [15:0]                   m_drp_do,
  input  logic [15:0]                   m_drp_di,
  output logic                          m_drp_en,
  output logic                          m_drp_we,
  input  logic                          m_drp_rdy,
  output logic [$clog2(PORTS)-1:0]      grant,
  output logic                          busy,
  output logic                          timeout
);

  localparam int SEL_WIDTH = $clog2(PORTS);
  localparam int IW        = SEL_WIDTH + 1;
  localparam int CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  logic [0:0]             state;
  logic [PORTS-1:0]       pending;
  logic [ADDR_WIDTH-1:0]  hold_addr [PORTS];
  logic [15:0]            hold_di   [PORTS];
  logic                   hold_we   [PORTS];
  logic [SEL_WIDTH-1:0]   rr;
  logic [SEL_WIDTH-1:0]   rr_next;
  logic [SEL_WIDTH-1:0]   sel;
  logic [IW-1:0]          idx;
  logic                   found;
  logic [CNT_W-1:0]       cnt;
  logic                   wd_fire;
  logic                   done;

  // First pending port scanning rr, rr+1, ... modulo PORTS.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 0; k < PORTS; k++) begin
      idx = {1'b0, rr} + IW'(k);
      if (idx >= IW'(PORTS)) idx = idx - IW'(PORTS);
      if (!found && pending[idx[SEL_WIDTH-1:0]]) begin
        found = 1'b1;
        sel   = idx[SEL_WIDTH-1:0];
      end
    end
  end

  assign rr_next = (sel == SEL_WIDTH'(PORTS - 1)) ? '0 : sel + 1'b1;
  assign wd_fire = (TIMEOUT != 0) && !m_drp_rdy && (cnt == CNT_MAX);
  assign done    = (state == ST_WAIT) && (m_drp_rdy || wd_fire);
  assign busy    = (state == ST_WAIT);

  // Request capture; the completing port's pending bit is released on the done edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending    <= '0;
      s_drp_drop <= '0;
      for (int i = 0; i < PORTS; i++) begin
        hold_addr[i] <= '0;
        hold_di[i]   <= '0;
        hold_we[i]   <= 1'b0;
      end
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        s_drp_drop[i] <= s_drp_en[i] && pending[i];
        if (s_drp_en[i] && !pending[i]) begin
          hold_addr[i] <= s_drp_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          hold_di[i]   <= s_drp_di[i*16 +: 16];
          hold_we[i]   <= s_drp_we[i];
          pending[i]   <= 1'b1;
        end
      end
      if (done) pending[grant] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      rr         <= '0;
      cnt        <= '0;
      grant      <= '0;
      m_drp_addr <= '0;
      m_drp_do   <= '0;
      m_drp_we   <= 1'b0;
      m_drp_en   <= 1'b0;
      s_drp_do   <= '0;
      s_drp_rdy  <= '0;
      timeout    <= 1'b0;
    end else begin
      m_drp_en  <= 1'b0;
      s_drp_rdy <= '0;
      timeout   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (found) begin
            state      <= ST_WAIT;
            m_drp_addr <= hold_addr[sel];
            m_drp_do   <= hold_di[sel];
            m_drp_we   <= hold_we[sel];
            m_drp_en   <= 1'b1;
            grant      <= sel;
            rr         <= rr_next;
            cnt        <= '0;
          end
        end
        ST_WAIT: begin
          if (m_drp_rdy) begin
            state                  <= ST_IDLE;
            s_drp_do[grant*16 +: 16] <= m_drp_di;
            s_drp_rdy[grant]       <= 1'b1;
          end else if (wd_fire) begin
            state                  <= ST_IDLE;
            s_drp_do[grant*16 +: 16] <= 16'hFFFF;
            s_drp_rdy[grant]       <= 1'b1;
            timeout                <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
